// File: rtl/rtl_settings_pkg.sv
// rtl/rtl_settings_pkg.sv - shared types for the memory test sequencer
// MEM_CHK_GAP_EN adds the GAP sequencer state.
package rtl_settings_pkg;

  localparam int TRANS_CNT_W = 32;

  typedef enum logic [1:0] {
    WR_ONLY = 2'd0,
    RD_ONLY = 2'd1,
    WR_RD   = 2'd2
  } test_mode_t;

  localparam logic [1:0] MODE_RSVD = 2'd3;

`ifdef MEM_CHK_GAP_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } seq_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3
  } seq_state_t;
`endif

endpackage

// File: rtl/mem_test_sequencer.sv
// rtl/mem_test_sequencer.sv - issues one command per generated address for a memory test run
// MEM_CHK_GAP_EN adds gap_i and idle cycles between commands.
module mem_test_sequencer
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W = 27
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   test_start_i,
  input  logic [1:0]             test_mode_i,
  input  logic [TRANS_CNT_W-1:0] trans_cnt_i,
  input  logic                   stop_i,
`ifdef MEM_CHK_GAP_EN
  input  logic [7:0]             gap_i,
`endif
  output logic                   addr_start_o,
  output logic                   next_addr_en_o,
  input  logic [ADDR_W-1:0]      next_addr_i,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic                   cmd_write_o,
  output logic [ADDR_W-1:0]      cmd_addr_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [TRANS_CNT_W-1:0] trans_done_o
);

  seq_state_t             r_state;
  seq_state_t             w_next_state;
  logic [1:0]             r_mode;
  logic [TRANS_CNT_W-1:0] r_cnt;
  logic [TRANS_CNT_W-1:0] r_done_cnt;
  logic                   r_stop;
  logic                   r_phase;
`ifdef MEM_CHK_GAP_EN
  logic [7:0]             r_gap;
  logic [7:0]             r_gap_cnt;
`endif

  logic w_hs;
  logic w_wr_beat;
  logic w_complete;
  logic w_last;
  logic w_start;

  assign w_start    = (r_state == S_IDLE) & test_start_i;
  assign w_hs       = (r_state == S_ISSUE) & cmd_ready_i;
  // r_phase=1 marks the write beat of a WR_RD address
  assign w_wr_beat  = (r_mode == WR_RD) & r_phase;
  assign w_complete = w_hs & ~w_wr_beat;
  assign w_last     = w_complete & (((r_done_cnt + 32'd1) == r_cnt) | r_stop);

  assign cmd_addr_o   = next_addr_i;
  assign busy_o       = (r_state != S_IDLE);
  assign trans_done_o = r_done_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_cnt      <= '0;
      r_done_cnt <= '0;
      r_stop     <= 1'b0;
      r_phase    <= 1'b1;
`ifdef MEM_CHK_GAP_EN
      r_gap      <= 8'd0;
      r_gap_cnt  <= 8'd0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_mode     <= test_mode_i;
        r_cnt      <= trans_cnt_i;
        r_done_cnt <= '0;
        r_stop     <= 1'b0;
        r_phase    <= 1'b1;
`ifdef MEM_CHK_GAP_EN
        r_gap      <= gap_i;
`endif
      end else begin
        if ((r_state != S_IDLE) && stop_i) r_stop <= 1'b1;
        if (w_hs) begin
          if (w_wr_beat) begin
            r_phase <= 1'b0;
          end else begin
            r_phase    <= 1'b1;
            r_done_cnt <= r_done_cnt + 32'd1;
          end
        end
`ifdef MEM_CHK_GAP_EN
        if (w_hs) r_gap_cnt <= r_gap;
        else if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - 8'd1;
`endif
      end
    end
  end

  always_comb begin
    w_next_state   = r_state;
    addr_start_o   = 1'b0;
    cmd_valid_o    = 1'b0;
    cmd_write_o    = 1'b0;
    next_addr_en_o = 1'b0;
    done_o         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (test_start_i) begin
          if ((trans_cnt_i == '0) || (test_mode_i == MODE_RSVD)) w_next_state = S_DONE;
          else w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        addr_start_o = 1'b1;
        w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        cmd_valid_o    = 1'b1;
        cmd_write_o    = (r_mode == WR_RD) ? r_phase : (r_mode == WR_ONLY);
        next_addr_en_o = w_complete;
        if (w_last) w_next_state = S_DONE;
`ifdef MEM_CHK_GAP_EN
        else if (w_hs && (r_gap != 8'd0)) w_next_state = S_GAP;
`endif
      end
`ifdef MEM_CHK_GAP_EN
      S_GAP: begin
        if (r_gap_cnt <= 8'd1) w_next_state = S_ISSUE;
      end
`endif
      S_DONE: begin
        done_o       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_test_sequencer.sv
// tb/tb_mem_test_sequencer.sv - randomized self-checking bench for mem_test_sequencer
// Gap scenarios run only when MEM_CHK_GAP_EN is defined.
module tb_mem_test_sequencer;

  localparam int AW = 27;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          test_start_i;
  logic [1:0]    test_mode_i;
  logic [31:0]   trans_cnt_i;
  logic          stop_i;
`ifdef MEM_CHK_GAP_EN
  logic [7:0]    gap_i;
`endif
  logic          addr_start_o;
  logic          next_addr_en_o;
  logic [AW-1:0] next_addr_i;
  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic          cmd_write_o;
  logic [AW-1:0] cmd_addr_o;
  logic          busy_o;
  logic          done_o;
  logic [31:0]   trans_done_o;

  logic [AW-1:0] gen_base;
  logic [AW-1:0] gen_stride;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_test_sequencer #(.ADDR_W(AW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .test_start_i   (test_start_i),
    .test_mode_i    (test_mode_i),
    .trans_cnt_i    (trans_cnt_i),
    .stop_i         (stop_i),
`ifdef MEM_CHK_GAP_EN
    .gap_i          (gap_i),
`endif
    .addr_start_o   (addr_start_o),
    .next_addr_en_o (next_addr_en_o),
    .next_addr_i    (next_addr_i),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_ready_i    (cmd_ready_i),
    .cmd_write_o    (cmd_write_o),
    .cmd_addr_o     (cmd_addr_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .trans_done_o   (trans_done_o)
  );

  // behavioural address generator: base on load, +stride on each advance
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) next_addr_i <= '0;
    else if (addr_start_o) next_addr_i <= gen_base;
    else if (next_addr_en_o) next_addr_i <= next_addr_i + gen_stride;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input longint idx);
    logic [AW-1:0] iv;
    iv = AW'(idx);
    return gen_base + iv * gen_stride;
  endfunction

  // One run. stop_beat (WR_RD write beat index) raises stop_i during that beat's handshake.
  task automatic run(input logic [1:0] mode, input logic [31:0] n, input int pct, input int hold,
                     input int stop_beat, input int busy_start_cyc, input int gap);
    longint bpt;
    longint n_eff;
    longint beats_exp;
    longint beats;
    int     cyc;
    int     first_cyc;
    int     prev_hs;
    int     last_hs;
    int     hold_left;
    bit     active;
    bit     done_seen;
    logic   rdy;
    logic   exp_wr;
    logic   exp_cmp;
    bpt    = (mode == 2'd2) ? 2 : 1;
    active = (n != 0) && (mode != 2'd3);
    n_eff  = active ? longint'(n) : 0;
    if (active && stop_beat >= 0 && (stop_beat / bpt + 1) < n_eff) n_eff = stop_beat / bpt + 1;
    beats_exp  = n_eff * bpt;
    gen_base   = AW'($urandom);
    gen_stride = AW'($urandom_range(1, 64));

    @(posedge clk_i); #1;
    test_mode_i  = mode;
    trans_cnt_i  = n;
    test_start_i = 1'b1;
`ifdef MEM_CHK_GAP_EN
    gap_i = 8'(gap);
`endif
    @(posedge clk_i); #1;
    test_start_i = 1'b0;
    test_mode_i  = 2'($urandom);
    trans_cnt_i  = $urandom;
`ifdef MEM_CHK_GAP_EN
    gap_i = 8'($urandom);
`endif
    cyc = 1;
    @(negedge clk_i);
    check("addr_start_t1", addr_start_o, active);
    check("busy_t1", busy_o, 1);
    check("done_t1", done_o, !active);
    check("valid_t1", cmd_valid_o, 0);
    if (!active) begin
      check("trans_done_empty", trans_done_o, 0);
      @(negedge clk_i);
      check("busy_after_empty", busy_o, 0);
      return;
    end

    beats = 0; first_cyc = -1; prev_hs = -1; last_hs = -1;
    hold_left = hold; done_seen = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk_i); #1;
      cyc++;
      rdy = ($urandom_range(0, 99) < pct);
      if (hold_left > 0 && cmd_valid_o) begin
        rdy = 1'b0;
        hold_left--;
      end
      cmd_ready_i  = rdy;
      stop_i       = (beats == stop_beat) && cmd_valid_o && rdy;
      test_start_i = (cyc == busy_start_cyc);
      @(negedge clk_i);
      if (cmd_valid_o && first_cyc < 0) begin
        first_cyc = cyc;
        check("first_valid_cyc", cyc, 2);
      end
      if (cmd_valid_o && cmd_ready_i) begin
        if (beats >= beats_exp) check("extra_beat", beats, beats_exp - 1);
        exp_wr  = (mode == 2'd0) ? 1'b1 : (mode == 2'd1) ? 1'b0 : (beats % bpt == 0);
        exp_cmp = (beats % bpt == bpt - 1);
        check("cmd_write", cmd_write_o, exp_wr);
        check("cmd_addr", cmd_addr_o, exp_addr(beats / bpt));
        check("next_addr_en_hs", next_addr_en_o, exp_cmp);
        check("trans_done_run", trans_done_o, beats / bpt);
        if (gap > 0 && prev_hs >= 0) check("hs_spacing", cyc - prev_hs, gap + 1);
        prev_hs = cyc;
        if (exp_cmp) last_hs = cyc;
        beats++;
      end else begin
        check("next_addr_en_idle", next_addr_en_o, 0);
        if (gap == 0 && first_cyc >= 0 && beats < beats_exp) begin
          check("valid_held", cmd_valid_o, 1);
          check("addr_held", cmd_addr_o, exp_addr(beats / bpt));
        end
      end
      if (done_o) begin
        done_seen = 1;
        break;
      end
    end
    check("done_seen", done_seen, 1);
    check("done_latency", cyc, last_hs + 1);
    check("beats_total", beats, beats_exp);
    check("trans_done_final", trans_done_o, n_eff);
    @(posedge clk_i); #1;
    cmd_ready_i = 1'b0; stop_i = 1'b0; test_start_i = 1'b0;
    @(negedge clk_i);
    check("busy_after_done", busy_o, 0);
    check("done_one_cycle", done_o, 0);
    check("trans_done_hold", trans_done_o, n_eff);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, cmd_valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_addr_start"}, addr_start_o, 0);
    check({tag, "_next_en"}, next_addr_en_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_cmd_write"}, cmd_write_o, 0);
    check({tag, "_trans_done"}, trans_done_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; test_start_i = 1'b0; test_mode_i = 2'd0; trans_cnt_i = '0;
    stop_i = 1'b0; cmd_ready_i = 1'b0; gen_base = '0; gen_stride = '0;
`ifdef MEM_CHK_GAP_EN
    gap_i = 8'd0;
`endif
    repeat (2) @(negedge clk_i);
    check_quiet("reset");
    check("reset_cmd_addr", cmd_addr_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    run(2'd0, 32'd4, 100, 0, -1, -1, 0);
    run(2'd2, 32'd2, 100, 0, -1, -1, 0);
    run(2'd1, 32'd3, 100, 5, -1, -1, 0);
    run(2'd0, 32'd0, 100, 0, -1, -1, 0);
    run(2'd3, 32'd5, 100, 0, -1, -1, 0);
    run(2'd2, 32'd10, 100, 0, 4, 5, 0);
    run(2'd2, 32'hFFFF_FFFF, 70, 0, 2, -1, 0);
    for (int r = 0; r < 8; r++) begin
      run(2'($urandom_range(0, 2)), 32'($urandom_range(1, 8)), $urandom_range(40, 100), 0, -1,
          $urandom_range(2, 12), 0);
    end
`ifdef MEM_CHK_GAP_EN
    run(2'd0, 32'd3, 100, 0, -1, -1, 2);
    run(2'd2, 32'd3, 100, 0, -1, -1, 1);
    run(2'd1, 32'd4, 100, 0, -1, -1, 0);
`endif

    // reset in the middle of a run
    gen_base = AW'($urandom); gen_stride = AW'(1);
    @(posedge clk_i); #1;
    test_mode_i = 2'd0; trans_cnt_i = 32'd20; test_start_i = 1'b1; cmd_ready_i = 1'b1;
`ifdef MEM_CHK_GAP_EN
    gap_i = 8'd2;
`endif
    @(posedge clk_i); #1;
    test_start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    check("pre_reset_busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check_quiet("async_reset");
    @(negedge clk_i);
    check_quiet("reset_held");
    @(posedge clk_i); #1;
    rst_i = 1'b0; cmd_ready_i = 1'b0;
    run(2'd1, 32'd2, 100, 0, -1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_test_sequencer.md
# mem_test_sequencer

Sequences one memory test run. On a start pulse it loads the address generator, then issues one command per generated address to the memory command interface, using a valid/ready handshake. In write-then-read mode each address gets a write followed by a read. It counts completed transactions and reports done. It sits between the CSR block and the memory master, and owns the address generator's `test_start` and `next_addr_en` inputs.

## Interface
- `ADDR_W`, default 27: address width, equal to the address generator's width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `test_start_i`  in  1  single-cycle start pulse from the CSR block.
- `test_mode_i`  in  2  `test_mode_t`, sampled on start.
- `trans_cnt_i`  in  32  number of transactions in the run, sampled on start.
- `stop_i`  in  1  stop request from the error checker; level or pulse.
- `addr_start_o`  out  1  drives the address generator's `test_start`.
- `next_addr_en_o`  out  1  drives the address generator's `next_addr_en`.
- `next_addr_i`  in  ADDR_W  current generated address.
- `cmd_valid_o`  out  1  command valid.
- `cmd_ready_i`  in  1  command accepted.
- `cmd_write_o`  out  1  1 = write, 0 = read.
- `cmd_addr_o`  out  ADDR_W  command address; combinational copy of `next_addr_i`.
- `busy_o`  out  1  run in progress.
- `done_o`  out  1  single-cycle pulse at the end of a run.
- `trans_done_o`  out  32  completed transactions in the current or last run.

## Operation
- FSM states: IDLE, LOAD, ISSUE, DONE. Under `MEM_CHK_GAP_EN` there is also a GAP state.
- IDLE:
  - On `test_start_i`, capture `test_mode_i` and `trans_cnt_i`, clear `trans_done_o` and the stop latch.
  - Go to LOAD, or straight to DONE if the captured count is 0 or the mode is the reserved value 3.
- LOAD: `addr_start_o`=1 for exactly this one cycle. Next state is ISSUE.
- ISSUE: `cmd_valid_o`=1. `cmd_write_o` depends on mode:
  - WR_ONLY: 1.
  - RD_ONLY: 0.
  - WR_RD: a phase bit, 1 for the first beat of an address and 0 for the second.
- On a handshake (`cmd_valid_o` && `cmd_ready_i`):
  - If this is the WR_RD write beat, toggle the phase and stay on the same address. `next_addr_en_o` stays 0.
  - Otherwise the transaction is complete:
    - `trans_done_o`++ and `next_addr_en_o`=1 in the same cycle.
    - If `trans_done_o`+1 == the captured count, or the stop latch is set, go to DONE. Otherwise stay in ISSUE.
- `next_addr_en_o` is asserted only on a completing handshake. The address therefore stays stable while `cmd_valid_o` is high.
- `stop_i` sets a sticky latch in any non-IDLE state:
  - The command currently offered is never withdrawn; `cmd_valid_o` drops only after a handshake.
  - In WR_RD, the read beat of the current address still completes before DONE.
- DONE: `done_o`=1 for one cycle, then IDLE. `trans_done_o` holds its value until the next start.
- `test_start_i` outside IDLE is ignored.
- `busy_o`=1 in every state except IDLE.
- Counter is 32-bit unsigned. A captured count of 0xFFFF_FFFF is legal; the counter never wraps because the run ends at equality.

## Timing
- Reset values: state IDLE; all outputs 0 except `cmd_addr_o`, which follows `next_addr_i`; `trans_done_o` = 0.
- Start at cycle T: `addr_start_o` high at T+1. First `cmd_valid_o` at T+2.
- Zero-bubble issue: with `cmd_ready_i` held at 1, there is one command per cycle. The new address is valid the cycle after `next_addr_en_o`.
- The last completing handshake at cycle C gives `done_o` at C+1 and `busy_o` low at C+2.
- Reset asserted mid-run returns to IDLE immediately and drops `cmd_valid_o`. The master resets on the same `rst_i`.

## Configuration
- `MEM_CHK_GAP_EN` defined:
  - Adds input port `gap_i` (8 bits, sampled on start) and a GAP state.
  - After every handshake, `cmd_valid_o` is held low for `gap_i` cycles before the next command.
  - `gap_i`=0 behaves exactly like the macro being undefined.
  - The stop latch is still honoured after the gap.
- `MEM_CHK_GAP_EN` undefined: no port, no GAP state, back-to-back issue.

## Structure
- `rtl_settings_pkg` gains:
  - `test_mode_t`: WR_ONLY=2'd0, RD_ONLY=2'd1, WR_RD=2'd2.
  - `seq_state_t`.
  - The 32-bit transaction counter width constant.
- Single module, no sub-module. The gap counter is inline.

## Test plan
- WR_ONLY, count=4, ready always 1: four writes on consecutive cycles from T+2, `next_addr_en_o` high on each, `done_o` at T+6, `trans_done_o`=4.
- WR_RD, count=2, ready always 1: beats W a0, R a0, W a1, R a1; `next_addr_en_o` high only on the R beats; `trans_done_o`=2.
- RD_ONLY, count=3, `cmd_ready_i` low for 5 cycles on the first command: `cmd_valid_o` and `cmd_addr_o` stay stable for 5 cycles, no `next_addr_en_o`, then 3 reads complete.
- count=0 start: `done_o` at T+1, `addr_start_o` never asserted, no command issued.
- WR_RD, count=10, `stop_i` pulsed during the 3rd write beat: that write and its read complete, `done_o` follows, `trans_done_o`=3; a `test_start_i` while busy is ignored.
- `MEM_CHK_GAP_EN` with `gap_i`=2, WR_ONLY, count=3: handshakes spaced 3 cycles apart; reset asserted mid-run returns to IDLE with all outputs 0.
